// File: rtl/mem_stage_pkg.sv
// Shared widths and bus layouts for the memory-access stage.
package mem_stage_pkg;

  localparam int ES_BUS_WD = 184;
  localparam int WS_BUS_WD = 172;
  localparam int FWD_WD    = 40;

  // Execute-to-memory payload, MSB first.
  typedef struct packed {
    logic [31:0] csr_wdata;     // 183:152
    logic [31:0] csr_wmask;     // 151:120
    logic [13:0] csr_num;       // 119:106
    logic        csr_we;        // 105
    logic [15:0] excp_num;      // 104:89
    logic        excp;          // 88
    logic        mul_div_sign;  // 87
    logic [3:0]  mul_div_op;    // 86:83
    logic [1:0]  addr_lo;       // 82:81
    logic        mem_we;        // 80
    logic        ld_w;          // 79
    logic        ld_b;          // 78
    logic        ld_bu;         // 77
    logic        ld_h;          // 76
    logic        ld_hu;         // 75
    logic        st_w;          // 74
    logic        st_b;          // 73
    logic        st_h;          // 72
    logic        res_from_csr;  // 71
    logic        res_from_mem;  // 70
    logic        gr_we;         // 69
    logic [4:0]  dest;          // 68:64
    logic [31:0] alu_result;    // 63:32
    logic [31:0] pc;            // 31:0
  } es_to_ms_t;

  // Memory-to-writeback payload, MSB first.
  typedef struct packed {
    logic [31:0] csr_wdata;     // 171:140
    logic [31:0] csr_wmask;     // 139:108
    logic [13:0] csr_num;       // 107:94
    logic        csr_we;        // 93
    logic [15:0] excp_num;      // 92:77
    logic        excp;          // 76
    logic        mul_div_sign;  // 75
    logic [3:0]  mul_div_op;    // 74:71
    logic        res_from_csr;  // 70
    logic        gr_we;         // 69
    logic [4:0]  dest;          // 68:64
    logic [31:0] final_result;  // 63:32
    logic [31:0] pc;            // 31:0
  } ms_to_ws_t;

  // Forwarding bus to decode.
  typedef struct packed {
    logic        load_pending;  // 39
    logic [31:0] result;        // 38:7
    logic [4:0]  dest;          // 6:2
    logic        gr_we;         // 1
    logic        valid;         // 0
  } ms_fwd_t;

endpackage

// File: rtl/mem_load_align.sv
// Selects and extends the addressed byte/halfword of a load response.
module mem_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic        ld_b,
  input  logic        ld_bu,
  input  logic        ld_h,
  input  logic        ld_hu,
  input  logic        ld_w,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection by the low address bits.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Sign/zero extension by load type; full word otherwise.
  always_comb begin
    load_data = rdata;
    if (ld_w)       load_data = rdata;
    else if (ld_b)  load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_bu) load_data = {24'd0, byte_sel};
    else if (ld_h)  load_data = {{16{half_sel[15]}}, half_sel};
    else if (ld_hu) load_data = {16'd0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the execute payload, waits for the
// data SRAM response, aligns load data and drops responses of killed
// instructions.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ES_TO_MS_BUS_WD = ES_BUS_WD,
  parameter int MS_TO_WS_BUS_WD = WS_BUS_WD,
  parameter int MS_FORWARD_WD   = FWD_WD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FORWARD_WD-1:0]   ms_forward,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       excp_flush,
  input  logic                       ertn_flush
);

  es_to_ms_t   ms_bus;
  ms_to_ws_t   ws_bus;
  ms_fwd_t     fwd;
  logic        ms_valid;
  logic        resp_got;
  logic [31:0] rdata_buf;
  logic [1:0]  discard_cnt;

  logic        need_resp;
  logic        data_ok_own;
  logic        resp_ok;
  logic        ms_ready_go;
  logic        flush;
  logic        accept;
  logic        depart;
  logic        discard_inc;
  logic        discard_dec;
  logic [31:0] load_rdata;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        unused_st;

  assign unused_st = ^{ms_bus.st_h, ms_bus.st_b, ms_bus.st_w};

  // Handshake; a response arriving this cycle already lets the instruction go.
  always_comb begin
    need_resp   = ms_bus.res_from_mem | ms_bus.mem_we;
    data_ok_own = data_sram_data_ok & (discard_cnt == 2'd0) & ms_valid
                  & need_resp & ~resp_got;
    resp_ok     = resp_got | data_ok_own;
    ms_ready_go = ~need_resp | resp_ok | ms_bus.excp;
    ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
    ms_to_ws_valid = ms_valid & ms_ready_go;
    flush       = excp_flush | ertn_flush;
    accept      = es_to_ms_valid & ms_allowin;
    depart      = ms_to_ws_valid & ws_allowin;
    // A killed instruction whose response is still in flight leaves one
    // response to be dropped later.
    discard_inc = ms_valid & need_resp & ~resp_ok & (flush | (depart & ms_bus.excp));
    discard_dec = data_sram_data_ok & (discard_cnt != 2'd0);
  end

  // Stage valid; flush wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (reset)           ms_valid <= 1'b0;
    else if (flush)      ms_valid <= 1'b0;
    else if (ms_allowin) ms_valid <= es_to_ms_valid;
  end

  // Payload register, loaded on accept only.
  always_ff @(posedge clk) begin
    if (accept) ms_bus <= es_to_ms_t'(es_to_ms_bus);
  end

  // Response-received flag; a new instruction always starts without one.
  always_ff @(posedge clk) begin
    if (reset)            resp_got <= 1'b0;
    else if (accept)      resp_got <= 1'b0;
    else if (data_ok_own) resp_got <= 1'b1;
  end

  // Read data buffer, held until the instruction leaves.
  always_ff @(posedge clk) begin
    if (data_ok_own) rdata_buf <= data_sram_rdata;
  end

  // Count of outstanding responses owned by killed instructions.
  always_ff @(posedge clk) begin
    if (reset) discard_cnt <= 2'd0;
    else if (discard_inc && !discard_dec && discard_cnt != 2'd3)
      discard_cnt <= discard_cnt + 2'd1;
    else if (discard_dec && !discard_inc)
      discard_cnt <= discard_cnt - 2'd1;
  end

  assign load_rdata = data_ok_own ? data_sram_rdata : rdata_buf;

  mem_load_align u_align (
    .rdata     (load_rdata),
    .addr_lo   (ms_bus.addr_lo),
    .ld_b      (ms_bus.ld_b),
    .ld_bu     (ms_bus.ld_bu),
    .ld_h      (ms_bus.ld_h),
    .ld_hu     (ms_bus.ld_hu),
    .ld_w      (ms_bus.ld_w),
    .load_data (load_data)
  );

  // Writeback payload and forwarding bus.
  always_comb begin
    final_result        = ms_bus.res_from_mem ? load_data : ms_bus.alu_result;
    ws_bus.csr_wdata    = ms_bus.csr_wdata;
    ws_bus.csr_wmask    = ms_bus.csr_wmask;
    ws_bus.csr_num      = ms_bus.csr_num;
    ws_bus.csr_we       = ms_bus.csr_we;
    ws_bus.excp_num     = ms_bus.excp_num;
    ws_bus.excp         = ms_bus.excp;
    ws_bus.mul_div_sign = ms_bus.mul_div_sign;
    ws_bus.mul_div_op   = ms_bus.mul_div_op;
    ws_bus.res_from_csr = ms_bus.res_from_csr;
    ws_bus.gr_we        = ms_bus.gr_we;
    ws_bus.dest         = ms_bus.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = ms_bus.pc;
    fwd.load_pending    = ms_valid & ms_bus.res_from_mem & ~resp_got & ~ms_bus.excp;
    fwd.result          = final_result;
    fwd.dest            = ms_bus.dest;
    fwd.gr_we           = ms_bus.gr_we;
    fwd.valid           = ms_valid;
  end

  assign ms_to_ws_bus = ws_bus;
  assign ms_forward   = fwd;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [183:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [171:0] ms_to_ws_bus;
  logic [39:0]  ms_forward;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         excp_flush;
  logic         ertn_flush;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_stage #(
    .ES_TO_MS_BUS_WD (184),
    .MS_TO_WS_BUS_WD (172),
    .MS_FORWARD_WD   (40)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_forward        (ms_forward),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .excp_flush        (excp_flush),
    .ertn_flush        (ertn_flush)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    bit          chk_res;
    logic [4:0]  dest;
    logic        gr_we;
    logic [3:0]  mdop;
    logic        excp;
    logic [15:0] excp_num;
    logic [31:0] csr_wdata;
  } exp_t;

  exp_t exp_q[$];

  // ld one-hot: [0]=ld_hu [1]=ld_h [2]=ld_bu [3]=ld_b [4]=ld_w
  localparam logic [4:0] LD_HU = 5'b00001;
  localparam logic [4:0] LD_H  = 5'b00010;
  localparam logic [4:0] LD_BU = 5'b00100;
  localparam logic [4:0] LD_B  = 5'b01000;
  localparam logic [4:0] LD_W  = 5'b10000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [183:0] mkbus(
    input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] dest,
    input logic gr_we, input logic rfm, input logic [4:0] ld, input logic mem_we,
    input logic [2:0] st, input logic [1:0] addr, input logic excp,
    input logic [15:0] ecode, input logic [3:0] mdop, input logic [31:0] csrw);
    logic [183:0] b;
    b = '0;
    b[31:0]    = pc;
    b[63:32]   = alu;
    b[68:64]   = dest;
    b[69]      = gr_we;
    b[70]      = rfm;
    b[74:72]   = st;
    b[79:75]   = ld;
    b[80]      = mem_we;
    b[82:81]   = addr;
    b[86:83]   = mdop;
    b[88]      = excp;
    b[104:89]  = ecode;
    b[183:152] = csrw;
    return b;
  endfunction

  task automatic push(input logic [31:0] pc, input logic [31:0] res, input bit chk_res,
                      input logic [4:0] dest, input logic gr_we, input logic [3:0] mdop,
                      input logic excp, input logic [15:0] ecode, input logic [31:0] csrw);
    exp_t e;
    e.pc = pc; e.res = res; e.chk_res = chk_res; e.dest = dest; e.gr_we = gr_we;
    e.mdop = mdop; e.excp = excp; e.excp_num = ecode; e.csr_wdata = csrw;
    exp_q.push_back(e);
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic issue(input logic [183:0] b);
    int k;
    k = 0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    while (!ms_allowin && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 20) begin
      n_vec++; n_miss++;
      $display("FAIL accept_timeout: got ms_allowin=0 for 20 cycles, required 1");
    end
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Monitor: every writeback transfer pops and checks one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && ms_to_ws_valid === 1'b1 && ws_allowin) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_transfer: got pc %h, required no transfer", ms_to_ws_bus[31:0]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ws_pc", ms_to_ws_bus[31:0], e.pc);
          if (e.chk_res) chk("ws_result", ms_to_ws_bus[63:32], e.res);
          chk("ws_dest", {27'd0, ms_to_ws_bus[68:64]}, {27'd0, e.dest});
          chk("ws_gr_we", {31'd0, ms_to_ws_bus[69]}, {31'd0, e.gr_we});
          chk("ws_mdop", {28'd0, ms_to_ws_bus[74:71]}, {28'd0, e.mdop});
          chk("ws_excp", {31'd0, ms_to_ws_bus[76]}, {31'd0, e.excp});
          chk("ws_excp_num", {16'd0, ms_to_ws_bus[92:77]}, {16'd0, e.excp_num});
          chk("ws_csr_wdata", ms_to_ws_bus[171:140], e.csr_wdata);
        end
      end
    end
  end

  logic [4:0]  lt_op   [6];
  logic [1:0]  lt_addr [6];
  logic [31:0] lt_rd   [6];
  logic [31:0] lt_exp  [6];

  initial begin
    lt_op[0] = LD_H;  lt_addr[0] = 2'd0; lt_rd[0] = 32'h1234_8001; lt_exp[0] = 32'hFFFF_8001;
    lt_op[1] = LD_BU; lt_addr[1] = 2'd1; lt_rd[1] = 32'h0000_F000; lt_exp[1] = 32'h0000_00F0;
    lt_op[2] = LD_H;  lt_addr[2] = 2'd2; lt_rd[2] = 32'h7FFF_0000; lt_exp[2] = 32'h0000_7FFF;
    lt_op[3] = LD_B;  lt_addr[3] = 2'd0; lt_rd[3] = 32'h0000_007F; lt_exp[3] = 32'h0000_007F;
    lt_op[4] = LD_HU; lt_addr[4] = 2'd0; lt_rd[4] = 32'h0000_9000; lt_exp[4] = 32'h0000_9000;
    lt_op[5] = LD_B;  lt_addr[5] = 2'd1; lt_rd[5] = 32'h0000_8500; lt_exp[5] = 32'hFFFF_FF85;

    reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A_5A5A;
    excp_flush = 1'b0; ertn_flush = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    chk("rst_ms_to_ws_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("rst_ms_allowin", {31'd0, ms_allowin}, 32'd1);
    chk("rst_fwd_valid", {31'd0, ms_forward[0]}, 32'd0);
    chk("rst_load_pending", {31'd0, ms_forward[39]}, 32'd0);
    cyc();

    // ld_b, addr 3, response one cycle after accept
    push(32'h1000_0000, 32'hFFFF_FF80, 1, 5'd4, 1'b1, 4'd0, 1'b0, 16'd0, 32'h0);
    issue(mkbus(32'h1000_0000, 32'h0000_0103, 5'd4, 1, 1, LD_B, 0, 3'b000, 2'd3, 0, 16'd0, 4'd0, 32'h0));
    chk("ldb_wait_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8011_2233;
    #1;
    chk("ldb_dataok_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    cyc();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A_5A5A;

    // ld_hu, addr 2, writeback stalled after the response
    ws_allowin = 1'b0;
    push(32'h1000_0004, 32'h0000_ABCD, 1, 5'd5, 1'b1, 4'd0, 1'b0, 16'd0, 32'h0);
    issue(mkbus(32'h1000_0004, 32'h0000_0202, 5'd5, 1, 1, LD_HU, 0, 3'b000, 2'd2, 0, 16'd0, 4'd0, 32'h0));
    chk("ldhu_pending_before", {31'd0, ms_forward[39]}, 32'd1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hABCD_1234;
    cyc();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5555_5555;
    repeat (3) begin
      chk("ldhu_hold_valid", {31'd0, ms_to_ws_valid}, 32'd1);
      chk("ldhu_hold_pending", {31'd0, ms_forward[39]}, 32'd0);
      chk("ldhu_hold_fwd_result", ms_forward[38:7], 32'h0000_ABCD);
      chk("ldhu_hold_allowin", {31'd0, ms_allowin}, 32'd0);
      cyc();
    end
    ws_allowin = 1'b1;
    cyc();
    chk("ldhu_no_dup", {31'd0, ms_to_ws_valid}, 32'd0);

    // ld_w killed by flush before its response; its response must be dropped
    issue(mkbus(32'h1000_0008, 32'h0, 5'd6, 1, 1, LD_W, 0, 3'b000, 2'd0, 0, 16'd0, 4'd0, 32'h0));
    excp_flush = 1'b1;
    cyc();
    excp_flush = 1'b0;
    chk("flush_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("flush_fwd_valid", {31'd0, ms_forward[0]}, 32'd0);
    chk("flush_allowin", {31'd0, ms_allowin}, 32'd1);
    push(32'h1000_000C, 32'h0000_BEEF, 1, 5'd7, 1'b1, 4'd0, 1'b0, 16'd0, 32'h0);
    issue(mkbus(32'h1000_000C, 32'h0, 5'd7, 1, 1, LD_W, 0, 3'b000, 2'd0, 0, 16'd0, 4'd0, 32'h0));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_DEAD;
    #1;
    chk("stale_ignored", {31'd0, ms_to_ws_valid}, 32'd0);
    cyc();
    data_sram_rdata = 32'h0000_BEEF;
    cyc();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A_5A5A;

    // st_w with ALE exception departs at once; its late response is dropped
    push(32'h1000_0010, 32'h0, 0, 5'd0, 1'b0, 4'd0, 1'b1, 16'h0009, 32'h0);
    issue(mkbus(32'h1000_0010, 32'h0000_0011, 5'd0, 0, 0, 5'd0, 1, 3'b100, 2'd1, 1, 16'h0009, 4'd0, 32'h0));
    chk("st_excp_ready", {31'd0, ms_to_ws_valid}, 32'd1);
    push(32'h1000_0014, 32'h2222_2222, 1, 5'd8, 1'b1, 4'd0, 1'b0, 16'd0, 32'h0);
    issue(mkbus(32'h1000_0014, 32'h0, 5'd8, 1, 1, LD_W, 0, 3'b000, 2'd0, 0, 16'd0, 4'd0, 32'h0));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
    #1;
    chk("st_late_resp_ignored", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("st_ld_pending", {31'd0, ms_forward[39]}, 32'd1);
    cyc();
    data_sram_rdata = 32'h2222_2222;
    cyc();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A_5A5A;

    // Back-to-back ALU instructions, one per cycle
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h0100_0000 + 32'(i * 32'h1111);
      push(32'h2000_0000 + 32'(i * 4), a, 1, 5'(10 + i), 1'b1, 4'(i + 3), 1'b0, 16'd0, 32'hC000_0000 + 32'(i));
      issue(mkbus(32'h2000_0000 + 32'(i * 4), a, 5'(10 + i), 1, 0, 5'd0, 0, 3'b000, 2'd0, 0, 16'd0,
                  4'(i + 3), 32'hC000_0000 + 32'(i)));
      chk("add_fwd_result", ms_forward[38:7], a);
      chk("add_fwd_pending", {31'd0, ms_forward[39]}, 32'd0);
      chk("add_fwd_dest", {27'd0, ms_forward[6:2]}, {27'd0, 5'(10 + i)});
      chk("add_allowin", {31'd0, ms_allowin}, 32'd1);
    end
    cyc();

    // Flush in the same cycle as the owning response: nothing left to drop
    issue(mkbus(32'h3000_0000, 32'h0, 5'd9, 1, 1, LD_W, 0, 3'b000, 2'd0, 0, 16'd0, 4'd0, 32'h0));
    ws_allowin = 1'b0;
    excp_flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_3333;
    cyc();
    excp_flush = 1'b0; data_sram_data_ok = 1'b0; ws_allowin = 1'b1;
    chk("own_flush_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    push(32'h3000_0004, 32'h4444_4444, 1, 5'd9, 1'b1, 4'd0, 1'b0, 16'd0, 32'h0);
    issue(mkbus(32'h3000_0004, 32'h0, 5'd9, 1, 1, LD_W, 0, 3'b000, 2'd0, 0, 16'd0, 4'd0, 32'h0));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h4444_4444;
    #1;
    chk("own_flush_next_captured", {31'd0, ms_to_ws_valid}, 32'd1);
    cyc();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A_5A5A;

    // ertn flush beats a same-cycle accept
    ertn_flush = 1'b1;
    issue(mkbus(32'h4000_0000, 32'h77, 5'd3, 1, 0, 5'd0, 0, 3'b000, 2'd0, 0, 16'd0, 4'd0, 32'h0));
    ertn_flush = 1'b0;
    chk("ertn_accept_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("ertn_accept_fwd", {31'd0, ms_forward[0]}, 32'd0);

    // Load alignment table
    for (int i = 0; i < 6; i++) begin
      push(32'h5000_0000 + 32'(i * 4), lt_exp[i], 1, 5'd20, 1'b1, 4'd0, 1'b0, 16'd0, 32'h0);
      issue(mkbus(32'h5000_0000 + 32'(i * 4), 32'h0, 5'd20, 1, 1, lt_op[i], 0, 3'b000, lt_addr[i],
                  0, 16'd0, 4'd0, 32'h0));
      data_sram_data_ok = 1'b1; data_sram_rdata = lt_rd[i];
      cyc();
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5A5A_5A5A;
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    if (exp_q.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL drain: got %0d transfers outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
